// File: rtl/reg_file_1h.sv
// ============================================================================
// Module   : reg_file_1h
// Brief    : 32 x 32-bit register file with a one-hot write select, two
//            combinational read ports, optional write-to-read bypass,
//            a sticky multi-hot error flag and a committed-write counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_1h #(
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] wsel,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    input  logic        err_clr,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic        err_onehot,
    output logic [15:0] wr_cnt
);

    localparam logic [31:0] c_ZERO = 32'h0000_0000;

    logic [31:0] r_mem [0:31];
    logic        r_err;
    logic [15:0] r_cnt;

    logic        w_any;
    logic        w_multi;
    logic        w_valid;
    logic        w_commit;
    logic        w_fwd_ok;
    logic        w_byp1;
    logic        w_byp2;

    // Classify the write select: at least one bit set, and more than one bit
    // set (clearing the lowest set bit leaves something behind).
    assign w_any    = |wsel;
    assign w_multi  = (wsel & (wsel - 32'd1)) != c_ZERO;
    assign w_valid  = we && w_any && !w_multi;
    // r0 is hard-wired zero, so a write aimed at it is not a committed write.
    assign w_commit = w_valid && !wsel[0];
    // Forwarding is suppressed while reset is held, since nothing can commit.
    assign w_fwd_ok = (BYPASS != 0) && w_valid && !rst;
    assign w_byp1   = w_fwd_ok && wsel[raddr1];
    assign w_byp2   = w_fwd_ok && wsel[raddr2];

    // Register storage: r1..r31 take wdata on a valid write to their bit;
    // r0 is held at zero permanently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 32; k++) begin
                r_mem[k] <= c_ZERO;
            end
        end else begin
            r_mem[0] <= c_ZERO;
            for (int k = 1; k < 32; k++) begin
                if (w_valid && wsel[k]) begin
                    r_mem[k] <= wdata;
                end
            end
        end
    end

    // Sticky multi-hot error flag; a new error on the clearing edge wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (we && w_multi) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    // Committed-write counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 16'h0000;
        end else if (w_commit) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Combinational read ports with optional same-cycle forwarding; index 0
    // always returns zero regardless of any pending write.
    always_comb begin
        rdata1 = c_ZERO;
        rdata2 = c_ZERO;
        if (raddr1 != 5'd0) begin
            rdata1 = w_byp1 ? wdata : r_mem[raddr1];
        end
        if (raddr2 != 5'd0) begin
            rdata2 = w_byp2 ? wdata : r_mem[raddr2];
        end
    end

    assign err_onehot = r_err;
    assign wr_cnt     = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_1h.sv
// ============================================================================
// Module   : tb_reg_file_1h
// Brief    : Directed self-checking bench for reg_file_1h; one instance with
//            forwarding and one without share all stimulus.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file_1h;

    logic        clk;
    logic        rst;
    logic        we;
    logic [31:0] wsel;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        err_clr;
    logic [31:0] rdata1_b, rdata2_b, rdata1_n, rdata2_n;
    logic        err_b, err_n;
    logic [15:0] cnt_b, cnt_n;

    int n_vec = 0;
    int n_err = 0;

    // Signal selectors for the scoreboard
    localparam int S_RD1  = 0;
    localparam int S_RD2  = 1;
    localparam int S_ERR  = 2;
    localparam int S_CNT  = 3;
    localparam int S_RD1N = 4;
    localparam int S_RD2N = 5;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    reg_file_1h #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .we(we), .wsel(wsel), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .err_clr(err_clr),
        .rdata1(rdata1_b), .rdata2(rdata2_b), .err_onehot(err_b), .wr_cnt(cnt_b)
    );

    reg_file_1h #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .we(we), .wsel(wsel), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .err_clr(err_clr),
        .rdata1(rdata1_n), .rdata2(rdata2_n), .err_onehot(err_n), .wr_cnt(cnt_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_RD1:   return rdata1_b;
            S_RD2:   return rdata2_b;
            S_ERR:   return {31'd0, err_b};
            S_CNT:   return {16'd0, cnt_b};
            S_RD1N:  return rdata1_n;
            S_RD2N:  return rdata2_n;
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic push(input string tag, input int sig, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Let combinational outputs settle, then pop and compare every pending entry
    task automatic chk();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sig);
            n_vec++;
            assert (obs === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] sel, input logic [31:0] d);
        we = 1'b1; wsel = sel; wdata = d;
        tick();
        we = 1'b0; wsel = 32'd0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wsel = 32'd0; wdata = 32'd0;
        raddr1 = 5'd5; raddr2 = 5'd31; err_clr = 1'b0;
        #3;
        push("reset_cnt", S_CNT, 32'd0);
        push("reset_err", S_ERR, 32'd0);
        push("reset_r5",  S_RD1, 32'd0);
        push("reset_r31", S_RD2, 32'd0);
        chk();
        @(negedge clk);
        rst = 1'b0;

        // Basic write to r5
        wr(32'h0000_0020, 32'hDEAD_BEEF);
        raddr1 = 5'd5;
        push("wr_r5",      S_RD1,  32'hDEAD_BEEF);
        push("wr_r5_nb",   S_RD1N, 32'hDEAD_BEEF);
        push("wr_r5_cnt",  S_CNT,  32'd1);
        chk();

        // Write to r0: bypass must not leak, count unchanged
        raddr1 = 5'd0; raddr2 = 5'd0;
        we = 1'b1; wsel = 32'h0000_0001; wdata = 32'h1234_5678;
        push("r0_byp_rd1", S_RD1, 32'd0);
        push("r0_byp_rd2", S_RD2, 32'd0);
        chk();
        tick();
        we = 1'b0; wsel = 32'd0;
        push("r0_after", S_RD1, 32'd0);
        push("r0_cnt",   S_CNT, 32'd1);
        chk();

        // Zero select: no write, no error
        wr(32'd0, 32'hFFFF_FFFF);
        push("zsel_err", S_ERR, 32'd0);
        push("zsel_cnt", S_CNT, 32'd1);
        chk();

        // Multi-hot write rejected and flagged
        wr(32'h0000_0008, 32'h1111_1111);
        wr(32'h0000_0010, 32'h2222_2222);
        wr(32'h0000_0018, 32'hFFFF_FFFF);
        raddr1 = 5'd3; raddr2 = 5'd4;
        push("multi_r3",  S_RD1, 32'h1111_1111);
        push("multi_r4",  S_RD2, 32'h2222_2222);
        push("multi_err", S_ERR, 32'd1);
        push("multi_cnt", S_CNT, 32'd3);
        chk();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        push("err_clr", S_ERR, 32'd0);
        chk();

        // we=0 with multi-hot select: no error check
        wsel = 32'h0000_0006;
        tick();
        wsel = 32'd0;
        push("we0_multi_err", S_ERR, 32'd0);
        chk();

        // Set wins over clear on the same edge
        we = 1'b1; wsel = 32'h0000_0006; err_clr = 1'b1;
        tick();
        we = 1'b0; wsel = 32'd0; err_clr = 1'b0;
        push("set_wins", S_ERR, 32'd1);
        chk();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        push("set_wins_clr", S_ERR, 32'd0);
        chk();

        // Bypass vs no-bypass on r7
        wr(32'h0000_0080, 32'hAAAA_0000);
        raddr1 = 5'd7; raddr2 = 5'd7;
        we = 1'b1; wsel = 32'h0000_0080; wdata = 32'h0000_BBBB;
        push("byp_rd1",   S_RD1,  32'h0000_BBBB);
        push("byp_rd2",   S_RD2,  32'h0000_BBBB);
        push("nbyp_rd1",  S_RD1N, 32'hAAAA_0000);
        push("nbyp_rd2",  S_RD2N, 32'hAAAA_0000);
        chk();
        tick();
        we = 1'b0; wsel = 32'd0;
        push("nbyp_post1", S_RD1N, 32'h0000_BBBB);
        push("nbyp_post2", S_RD2N, 32'h0000_BBBB);
        push("byp_post1",  S_RD1,  32'h0000_BBBB);
        push("byp_cnt",    S_CNT,  32'd5);
        chk();

        // Counter wrap after a fresh reset
        rst = 1'b1;
        #1;
        rst = 1'b0;
        push("rst_r7", S_RD1, 32'd0);
        push("rst_cnt", S_CNT, 32'd0);
        chk();
        raddr1 = 5'd1;
        for (int i = 0; i < 65536; i++) begin
            wr(32'h0000_0002, i);
        end
        push("wrap_cnt", S_CNT, 32'd0);
        push("wrap_r1",  S_RD1, 32'h0000_FFFF);
        chk();
        wr(32'h0000_0002, 32'h0001_0000);
        push("wrap_cnt1", S_CNT, 32'd1);
        chk();

        // Asynchronous reset mid-write
        wr(32'h0000_0200, 32'h0000_0005);
        wr(32'h0000_0006, 32'd0);
        raddr1 = 5'd9;
        push("pre_r9",  S_RD1N, 32'h5);
        push("pre_err", S_ERR,  32'd1);
        chk();
        we = 1'b1; wsel = 32'h0000_0200; wdata = 32'h9;
        push("mid_byp", S_RD1, 32'h9);
        chk();
        rst = 1'b1;
        push("arst_r9",   S_RD1,  32'd0);
        push("arst_r9nb", S_RD1N, 32'd0);
        push("arst_err",  S_ERR,  32'd0);
        push("arst_cnt",  S_CNT,  32'd0);
        chk();
        rst = 1'b0; we = 1'b0; wsel = 32'd0;
        tick();
        push("post_r9",  S_RD1N, 32'd0);
        push("post_cnt", S_CNT,  32'd0);
        chk();

        // Write held across an edge under reset is discarded
        rst = 1'b1; we = 1'b1; wsel = 32'h0000_0200; wdata = 32'h7;
        tick();
        we = 1'b0; wsel = 32'd0;
        rst = 1'b0;
        push("rst_edge_r9",  S_RD1N, 32'd0);
        push("rst_edge_cnt", S_CNT,  32'd0);
        chk();

        // First edge after reset release accepts a write
        wr(32'h0000_0200, 32'h0000_0009);
        push("first_r9",  S_RD1N, 32'h9);
        push("first_cnt", S_CNT,  32'd1);
        chk();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
